// File: rtl/kmeans_pkg.sv
// Shared constants, FSM encoding and the saturating-add helper for the K-means distance blocks.
// The helper is only used when KMEANS_DIST_SAT_EN is defined.
package kmeans_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ACC_W_DEFAULT  = 40;
    localparam int SAT_W_MAX      = 64;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    // Adds two values of up to SAT_W_MAX bits and clamps the sum at 2^w-1.
    function automatic logic [SAT_W_MAX-1:0] sat_add(
        input logic [SAT_W_MAX-1:0] a,
        input logic [SAT_W_MAX-1:0] b,
        input int unsigned          w
    );
        logic [SAT_W_MAX:0] sum;
        logic [SAT_W_MAX:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W_MAX+1)'(1) << w) - (SAT_W_MAX+1)'(1);
        return (sum > lim) ? lim[SAT_W_MAX-1:0] : sum[SAT_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/kmeans_dist_argmin_if.sv
// Coordinate-pair input stream and nearest-centroid result stream of kmeans_dist_argmin.
interface kmeans_dist_argmin_if #(
    parameter int DATA_W = kmeans_pkg::DATA_W_DEFAULT,
    parameter int ACC_W  = kmeans_pkg::ACC_W_DEFAULT,
    parameter int IDX_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] p_coord;
    logic [DATA_W-1:0] c_coord;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  best_idx;
    logic [ACC_W-1:0]  best_dist;

    modport master (
        output in_valid, p_coord, c_coord, out_ready,
        input  in_ready, out_valid, best_idx, best_dist
    );

    modport slave (
        input  in_valid, p_coord, c_coord, out_ready,
        output in_ready, out_valid, best_idx, best_dist
    );
endinterface

// File: rtl/kmeans_absdiff.sv
// Combinational unsigned absolute difference |a-b|.
module kmeans_absdiff #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff
);
    assign diff = (a >= b) ? (a - b) : (b - a);
endmodule

// File: rtl/kmeans_dist_argmin.sv
// Manhattan distance per centroid with running argmin over K centroids; one result per point.
// Define KMEANS_DIST_SAT_EN to make accumulator adds saturate instead of wrap.
module kmeans_dist_argmin
    import kmeans_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DIM    = 4,
    parameter int K      = 4,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kmeans_dist_argmin_if.slave   bus
);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int DIM_W = (DIM > 1) ? $clog2(DIM) : 1;

    state_t             state_reg;
    logic [DIM_W-1:0]   dim_cnt_reg;
    logic [IDX_W-1:0]   cen_cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   min_dist_reg;
    logic [IDX_W-1:0]   min_idx_reg;
    logic [IDX_W-1:0]   best_idx_reg;
    logic [ACC_W-1:0]   best_dist_reg;
    logic               out_valid_reg;

    logic [DATA_W-1:0]  diff;
    logic [ACC_W-1:0]   d_ext;
    logic [ACC_W-1:0]   acc_sum;
    logic               xfer;
    logic               last_dim;
    logic               last_cen;
    logic               take_new;
    logic [ACC_W-1:0]   win_dist;
    logic [IDX_W-1:0]   win_idx;

    kmeans_absdiff #(.W(DATA_W)) u_absdiff (
        .a    (bus.p_coord),
        .b    (bus.c_coord),
        .diff (diff)
    );

    assign d_ext = ACC_W'(diff);

`ifdef KMEANS_DIST_SAT_EN
    assign acc_sum = ACC_W'(sat_add(SAT_W_MAX'(acc_reg), SAT_W_MAX'(d_ext), ACC_W));
`else
    assign acc_sum = acc_reg + d_ext;
`endif

    assign xfer     = bus.in_valid && (state_reg == ACCUM);
    assign last_dim = (dim_cnt_reg == DIM_W'(DIM - 1));
    assign last_cen = (cen_cnt_reg == IDX_W'(K - 1));

    // Strict less-than so an equal distance keeps the earlier (lower) index.
    assign take_new = (cen_cnt_reg == '0) || (acc_sum < min_dist_reg);
    assign win_dist = take_new ? acc_sum : min_dist_reg;
    assign win_idx  = take_new ? cen_cnt_reg : min_idx_reg;

    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = out_valid_reg;
    assign bus.best_idx  = best_idx_reg;
    assign bus.best_dist = best_dist_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            dim_cnt_reg   <= '0;
            cen_cnt_reg   <= '0;
            acc_reg       <= '0;
            min_dist_reg  <= '0;
            min_idx_reg   <= '0;
            best_idx_reg  <= '0;
            best_dist_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (xfer) begin
                        if (last_dim) begin
                            acc_reg      <= '0;
                            dim_cnt_reg  <= '0;
                            min_dist_reg <= win_dist;
                            min_idx_reg  <= win_idx;
                            if (last_cen) begin
                                cen_cnt_reg   <= '0;
                                best_idx_reg  <= win_idx;
                                best_dist_reg <= win_dist;
                                out_valid_reg <= 1'b1;
                                state_reg     <= RESULT;
                            end else begin
                                cen_cnt_reg <= cen_cnt_reg + IDX_W'(1);
                            end
                        end else begin
                            acc_reg     <= acc_sum;
                            dim_cnt_reg <= dim_cnt_reg + DIM_W'(1);
                        end
                    end
                end
                RESULT: begin
                    // Counters were zeroed on the final beat, so the next point can start at once.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ACCUM;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_dist_argmin.sv
// Directed bench for kmeans_dist_argmin across four configurations sharing one clock and reset.
module tb_kmeans_dist_argmin;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    kmeans_dist_argmin_if #(.DATA_W(32), .ACC_W(40), .IDX_W(1)) ia ();
    kmeans_dist_argmin_if #(.DATA_W(32), .ACC_W(40), .IDX_W(2)) ib ();
    kmeans_dist_argmin_if #(.DATA_W(32), .ACC_W(33), .IDX_W(1)) ic ();
    kmeans_dist_argmin_if #(.DATA_W(32), .ACC_W(40), .IDX_W(2)) id ();

    kmeans_dist_argmin #(.DATA_W(32), .DIM(2), .K(2), .ACC_W(40)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    kmeans_dist_argmin #(.DATA_W(32), .DIM(4), .K(4), .ACC_W(40)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    kmeans_dist_argmin #(.DATA_W(32), .DIM(3), .K(1), .ACC_W(33)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    kmeans_dist_argmin #(.DATA_W(32), .DIM(2), .K(4), .ACC_W(40)) dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [31:0] p, input logic [31:0] c);
        ia.in_valid = 1'b1; ia.p_coord = p; ia.c_coord = c;
        tick();
    endtask

    task automatic beat_d(input logic [31:0] p, input logic [31:0] c);
        id.in_valid = 1'b1; id.p_coord = p; id.c_coord = c;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", ia.out_valid); end
        checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", ia.in_ready); end
        checks++; if (ib.best_idx !== 2'd0) begin failures++; $display("FAIL reset_best_idx got=%0d exp=0", ib.best_idx); end
        checks++; if (ib.best_dist !== 40'd0) begin failures++; $display("FAIL reset_best_dist got=%0d exp=0", ib.best_dist); end
        rst_n = 1'b1;
        tick();
        $display("reset: done");
    endtask

    task automatic test_basic();
        ia.out_ready = 1'b1;
        beat_a(32'd50, 32'd13); beat_a(32'd10, 32'd10);
        beat_a(32'd50, 32'd48); beat_a(32'd10, 32'd12);
        ia.in_valid = 1'b0;
        checks++; if (ia.out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0b exp=1", ia.out_valid); end
        checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready got=%0b exp=0", ia.in_ready); end
        checks++; if (ia.best_idx !== 1'd1) begin failures++; $display("FAIL basic_idx got=%0d exp=1", ia.best_idx); end
        checks++; if (ia.best_dist !== 40'd4) begin failures++; $display("FAIL basic_dist got=%0d exp=4", ia.best_dist); end
        tick();
        checks++; if (ia.out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%0b exp=0", ia.out_valid); end
        $display("basic: idx=%0d dist=%0d", ia.best_idx, ia.best_dist);
    endtask

    task automatic test_tie();
        beat_a(32'd7, 32'd2); beat_a(32'd0, 32'd0);
        beat_a(32'd0, 32'd5); beat_a(32'd3, 32'd3);
        ia.in_valid = 1'b0;
        checks++; if (ia.best_idx !== 1'd0) begin failures++; $display("FAIL tie_idx got=%0d exp=0", ia.best_idx); end
        checks++; if (ia.best_dist !== 40'd5) begin failures++; $display("FAIL tie_dist got=%0d exp=5", ia.best_dist); end
        tick();
        $display("tie: idx=%0d dist=%0d", ia.best_idx, ia.best_dist);
    endtask

    task automatic test_backpressure();
        ia.out_ready = 1'b0;
        beat_a(32'd1, 32'd4); beat_a(32'd2, 32'd2);
        beat_a(32'd9, 32'd9); beat_a(32'd5, 32'd6);
        // Offer a stray beat during the stall; it must not be consumed.
        ia.in_valid = 1'b1; ia.p_coord = 32'd100; ia.c_coord = 32'd0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_hs cyc=%0d got=%0b/%0b exp=1/0", i, ia.out_valid, ia.in_ready); end
            checks++; if (ia.best_idx !== 1'd1 || ia.best_dist !== 40'd1) begin failures++; $display("FAIL bp_hold_val cyc=%0d got=%0d/%0d exp=1/1", i, ia.best_idx, ia.best_dist); end
            tick();
        end
        ia.out_ready = 1'b1;
        ia.p_coord = 32'd20; ia.c_coord = 32'd0;
        tick();
        checks++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b/%0b exp=0/1", ia.out_valid, ia.in_ready); end
        beat_a(32'd20, 32'd0); beat_a(32'd0, 32'd0);
        beat_a(32'd0, 32'd30); beat_a(32'd1, 32'd0);
        ia.in_valid = 1'b0;
        checks++; if (ia.out_valid !== 1'b1 || ia.best_idx !== 1'd0 || ia.best_dist !== 40'd20) begin failures++; $display("FAIL bp_next got=%0b/%0d/%0d exp=1/0/20", ia.out_valid, ia.best_idx, ia.best_dist); end
        tick();
        $display("backpressure: next idx=%0d dist=%0d", ia.best_idx, ia.best_dist);
    endtask

    task automatic test_reset_midpoint();
        id.out_ready = 1'b1;
        beat_d(32'd10, 32'd0); beat_d(32'd0, 32'd0);
        beat_d(32'd3, 32'd0);  beat_d(32'd0, 32'd1);
        beat_d(32'd0, 32'd2);  beat_d(32'd5, 32'd5);
        beat_d(32'd6, 32'd0);  beat_d(32'd0, 32'd0);
        id.in_valid = 1'b0;
        checks++; if (id.best_idx !== 2'd2 || id.best_dist !== 40'd2) begin failures++; $display("FAIL rst_pre got=%0d/%0d exp=2/2", id.best_idx, id.best_dist); end
        tick();
        beat_d(32'd1000, 32'd0); beat_d(32'd0, 32'd0); beat_d(32'd500, 32'd0);
        id.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (id.out_valid !== 1'b0 || id.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_hs got=%0b/%0b exp=0/1", id.out_valid, id.in_ready); end
        checks++; if (id.best_dist !== 40'd0 || id.best_idx !== 2'd0) begin failures++; $display("FAIL rst_mid_val got=%0d/%0d exp=0/0", id.best_idx, id.best_dist); end
        tick();
        rst_n = 1'b1;
        tick();
        beat_d(32'd4, 32'd0); beat_d(32'd0, 32'd0);
        beat_d(32'd0, 32'd3); beat_d(32'd0, 32'd0);
        beat_d(32'd2, 32'd2); beat_d(32'd0, 32'd1);
        beat_d(32'd5, 32'd3); beat_d(32'd9, 32'd9);
        id.in_valid = 1'b0;
        checks++; if (id.out_valid !== 1'b1 || id.best_idx !== 2'd2 || id.best_dist !== 40'd1) begin failures++; $display("FAIL rst_fresh got=%0b/%0d/%0d exp=1/2/1", id.out_valid, id.best_idx, id.best_dist); end
        tick();
        $display("reset_midpoint: fresh idx=%0d dist=%0d", id.best_idx, id.best_dist);
    endtask

    task automatic test_overflow();
        logic [32:0] exp_ov;
`ifdef KMEANS_DIST_SAT_EN
        exp_ov = 33'h1FFFFFFFF;
`else
        exp_ov = 33'h0FFFFFFFD;
`endif
        ic.out_ready = 1'b1;
        ic.in_valid = 1'b1; ic.p_coord = 32'hFFFFFFFF; ic.c_coord = 32'd0;
        repeat (3) tick();
        ic.in_valid = 1'b0;
        checks++; if (ic.out_valid !== 1'b1 || ic.best_idx !== 1'd0) begin failures++; $display("FAIL ovf_hs got=%0b/%0d exp=1/0", ic.out_valid, ic.best_idx); end
        checks++; if (ic.best_dist !== exp_ov) begin failures++; $display("FAIL ovf_dist got=%0h exp=%0h", ic.best_dist, exp_ov); end
        tick();
        $display("overflow: dist=%0h", ic.best_dist);
    endtask

    task automatic test_streaming();
        logic [31:0] sp [32];
        logic [31:0] sc [32];
        int exp_idx [2];
        int exp_dist [2];
        int got_idx [2];
        int got_dist [2];
        int res_cyc [2];
        int cyc = 0;
        int k = 0;
        int nres = 0;
        logic rdy;
        for (int i = 0; i < 32; i++) begin
            sp[i] = 32'((i * 97 + 13) % 211);
            sc[i] = 32'((i * 53 + 7) % 199);
        end
        for (int pt = 0; pt < 2; pt++) begin
            exp_idx[pt] = 0;
            exp_dist[pt] = 0;
            for (int cc = 0; cc < 4; cc++) begin
                int dsum = 0;
                for (int dd = 0; dd < 4; dd++) begin
                    int a = int'(sp[pt*16 + cc*4 + dd]);
                    int b = int'(sc[pt*16 + cc*4 + dd]);
                    dsum += (a >= b) ? (a - b) : (b - a);
                end
                if (cc == 0 || dsum < exp_dist[pt]) begin
                    exp_dist[pt] = dsum;
                    exp_idx[pt] = cc;
                end
            end
        end
        ib.out_ready = 1'b1;
        while (nres < 2 && cyc < 80) begin
            if (k < 32) begin
                ib.in_valid = 1'b1; ib.p_coord = sp[k]; ib.c_coord = sc[k];
            end else begin
                ib.in_valid = 1'b0;
            end
            rdy = ib.in_ready;
            tick();
            cyc++;
            if (rdy && k < 32) k++;
            if (ib.out_valid) begin
                got_idx[nres] = int'(ib.best_idx);
                got_dist[nres] = int'(ib.best_dist);
                res_cyc[nres] = cyc;
                $display("stream: result %0d at cycle %0d idx=%0d dist=%0d", nres, cyc, got_idx[nres], got_dist[nres]);
                nres++;
            end
        end
        ib.in_valid = 1'b0;
        checks++;
        if (nres != 2) begin
            failures++; $display("FAIL stream_timeout got=%0d results exp=2", nres);
        end else begin
            for (int pt = 0; pt < 2; pt++) begin
                checks++; if (got_idx[pt] != exp_idx[pt] || got_dist[pt] != exp_dist[pt]) begin failures++; $display("FAIL stream_val%0d got=%0d/%0d exp=%0d/%0d", pt, got_idx[pt], got_dist[pt], exp_idx[pt], exp_dist[pt]); end
            end
            checks++; if (res_cyc[1] - res_cyc[0] != 17) begin failures++; $display("FAIL stream_spacing got=%0d exp=17", res_cyc[1] - res_cyc[0]); end
            checks++; if (res_cyc[0] != 16) begin failures++; $display("FAIL stream_latency got=%0d exp=16", res_cyc[0]); end
        end
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.p_coord = '0; ia.c_coord = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.p_coord = '0; ib.c_coord = '0; ib.out_ready = 1'b1;
        ic.in_valid = 1'b0; ic.p_coord = '0; ic.c_coord = '0; ic.out_ready = 1'b1;
        id.in_valid = 1'b0; id.p_coord = '0; id.c_coord = '0; id.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_reset_midpoint();
        test_overflow();
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
